reg_counter_bank: RTL and testbench

REG_COUNTER_BANK -- requirements
Module: reg_counter_bank

---
 rtl/reg_counter_bank.sv | 143 ++++++++++++++
 tb/tb_reg_counter_bank.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_counter_bank.sv
// Bank of NUM_REGS counters driven by a 4-state control FSM: LOAD/INR/DCR take 2 cycles, DCRZ counts down to zero.
// A new operation is accepted only in IDLE; requests that arrive while busy are dropped.
module reg_counter_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REGS   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        op_valid_i,
   input  logic [1:0]                  op_i,
   input  logic [$clog2(NUM_REGS)-1:0] reg_sel_i,
   input  logic [DATA_WIDTH-1:0]       load_data_i,
   input  logic [$clog2(NUM_REGS)-1:0] rd_sel_i,
   output logic [DATA_WIDTH-1:0]       rd_data_o,
   output logic                        flag_zero_o,
   output logic                        flag_negative_o,
   output logic                        flag_carry_o,
   output logic                        busy_o,
   output logic                        instr_complete_o
);

   localparam int SEL_WIDTH = $clog2(NUM_REGS);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INR  = 2'b01;
   localparam logic [1:0] OP_DCR  = 2'b10;
   localparam logic [1:0] OP_DCRZ = 2'b11;

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      LOOP = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [1:0]             op_q;
   logic [SEL_WIDTH-1:0]   sel_q;
   logic [DATA_WIDTH-1:0]  data_q;

   logic [DATA_WIDTH-1:0]  regs [NUM_REGS];
   logic [DATA_WIDTH-1:0]  cur_val;
   logic [DATA_WIDTH:0]    inc_full;
   logic [DATA_WIDTH-1:0]  dec_val;

   logic                   accept;
   logic                   wr_en;
   logic [DATA_WIDTH-1:0]  wr_val;
   logic                   zero_nxt;
   logic                   neg_nxt;
   logic                   carry_nxt;

   assign cur_val  = regs[sel_q];
   assign inc_full = {1'b0, cur_val} + {{DATA_WIDTH{1'b0}}, 1'b1};
   assign dec_val  = cur_val - ONE;
   assign accept   = (state == IDLE) && op_valid_i;

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_val    = cur_val;
      carry_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (op_valid_i) state_nxt = EXEC;
         end
         EXEC: begin
            wr_en     = 1'b1;
            state_nxt = DONE;
            case (op_q)
               OP_LOAD: wr_val = data_q;
               OP_INR: begin
                  wr_val    = inc_full[DATA_WIDTH-1:0];
                  carry_nxt = inc_full[DATA_WIDTH];
               end
               OP_DCR: begin
                  wr_val    = dec_val;
                  carry_nxt = (cur_val == '0);
               end
               default: begin
                  // DCRZ on zero holds the register and finishes immediately
                  if (cur_val != '0) begin
                     wr_val    = dec_val;
                     state_nxt = (dec_val == '0) ? DONE : LOOP;
                  end
               end
            endcase
         end
         LOOP: begin
            wr_en     = 1'b1;
            wr_val    = dec_val;
            state_nxt = (dec_val == '0) ? DONE : LOOP;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      zero_nxt = (wr_val == '0);
      neg_nxt  = wr_val[DATA_WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         op_q            <= OP_LOAD;
         sel_q           <= '0;
         data_q          <= '0;
         flag_zero_o     <= 1'b0;
         flag_negative_o <= 1'b0;
         flag_carry_o    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q  <= op_i;
            sel_q <= reg_sel_i;
            if (op_i == OP_LOAD) data_q <= load_data_i;
         end
         if (wr_en) begin
            regs[sel_q]     <= wr_val;
            flag_zero_o     <= zero_nxt;
            flag_negative_o <= neg_nxt;
            flag_carry_o    <= carry_nxt;
         end
      end
   end

   assign rd_data_o        = regs[rd_sel_i];
   assign busy_o           = (state != IDLE);
   assign instr_complete_o = (state == DONE);

endmodule

// File: tb/tb_reg_counter_bank.sv
// Directed bench for reg_counter_bank: table of single-cycle ops plus hand sequences for DCRZ, ignored requests and reset abort.
module tb_reg_counter_bank;

   logic       clk;
   logic       reset;
   logic       op_valid;
   logic [1:0] op;
   logic [1:0] reg_sel;
   logic [7:0] load_data;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;
   logic       flag_z;
   logic       flag_n;
   logic       flag_c;
   logic       busy;
   logic       complete;

   int total  = 0;
   int passed = 0;

   reg_counter_bank #(.DATA_WIDTH(8), .NUM_REGS(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .op_valid_i       (op_valid),
      .op_i             (op),
      .reg_sel_i        (reg_sel),
      .load_data_i      (load_data),
      .rd_sel_i         (rd_sel),
      .rd_data_o        (rd_data),
      .flag_zero_o      (flag_z),
      .flag_negative_o  (flag_n),
      .flag_carry_o     (flag_c),
      .busy_o           (busy),
      .instr_complete_o (complete)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [1:0] sel;
      logic [7:0] data;
      logic [7:0] exp_val;
      logic       z;
      logic       n;
      logic       c;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reg(input string name, input logic [1:0] sel, input logic [7:0] exp);
      rd_sel = sel;
      #1;
      check(name, {24'd0, rd_data}, {24'd0, exp});
   endtask

   task automatic check_flags(input string name, input logic z, input logic n, input logic c);
      check(name, {29'd0, flag_z, flag_n, flag_c}, {29'd0, z, n, c});
   endtask

   // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that lands back in IDLE.
   task automatic run_op(input logic [1:0] o, input logic [1:0] sel, input logic [7:0] data,
                         input bit hold, input logic [1:0] alt_sel,
                         output int lat, output int busy_cnt);
      bit done;
      op_valid  = 1'b1;
      op        = o;
      reg_sel   = sel;
      load_data = data;
      @(posedge clk); #1;
      if (hold) begin
         op        = 2'b00;
         reg_sel   = alt_sel;
         load_data = 8'hAA;
      end else begin
         op_valid = 1'b0;
      end
      lat      = 0;
      busy_cnt = 0;
      done     = 1'b0;
      for (int i = 1; i <= 600 && !done; i++) begin
         if (busy) busy_cnt++;
         if (complete) begin
            lat      = i;
            done     = 1'b1;
            op_valid = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      check("op_completed", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      check("complete_one_cycle", {31'd0, complete}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   int lat;
   int bcnt;
   int pulses;

   initial begin
      vecs[0] = '{2'b00, 2'd2, 8'h06, 8'h06, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 2'd2, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{2'b10, 2'd2, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{2'b00, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{2'b10, 2'd1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{2'b01, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{2'b00, 2'd0, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{2'b01, 2'd0, 8'h00, 8'h81, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{2'b00, 2'd3, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{2'b01, 2'd3, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0};

      reset     = 1'b1;
      op_valid  = 1'b0;
      op        = 2'b00;
      reg_sel   = 2'd0;
      load_data = 8'h00;
      rd_sel    = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_complete", {31'd0, complete}, 32'd0);
      check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 4; r++) check_reg("reset_reg", r[1:0], 8'h00);
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[k]) begin
         run_op(vecs[k].op, vecs[k].sel, vecs[k].data, 1'b0, 2'd0, lat, bcnt);
         check("vec_latency", lat, 2);
         check("vec_busy_cycles", bcnt, 2);
         check("vec_reg", {24'd0, vecs[k].exp_val}, {24'd0, vecs[k].exp_val} & 32'hFF);
         check_reg("vec_value", vecs[k].sel, vecs[k].exp_val);
         check_flags("vec_flags", vecs[k].z, vecs[k].n, vecs[k].c);
      end
      check_reg("r2_after_table", 2'd2, 8'h04);

      // DCRZ from 4: five busy cycles, other registers untouched
      run_op(2'b00, 2'd3, 8'h04, 1'b0, 2'd0, lat, bcnt);
      run_op(2'b11, 2'd3, 8'h00, 1'b0, 2'd0, lat, bcnt);
      check("dcrz4_latency", lat, 5);
      check("dcrz4_busy", bcnt, 5);
      check_reg("dcrz4_r3", 2'd3, 8'h00);
      check_flags("dcrz4_flags", 1'b1, 1'b0, 1'b0);
      check_reg("dcrz4_r0", 2'd0, 8'h81);
      check_reg("dcrz4_r1", 2'd1, 8'h00);
      check_reg("dcrz4_r2", 2'd2, 8'h04);

      // DCRZ on zero register after flags were cleared by INR r1
      run_op(2'b00, 2'd0, 8'h00, 1'b0, 2'd0, lat, bcnt);
      run_op(2'b01, 2'd1, 8'h00, 1'b0, 2'd0, lat, bcnt);
      check_flags("inr_r1_flags", 1'b0, 1'b0, 1'b0);
      run_op(2'b11, 2'd0, 8'h00, 1'b0, 2'd0, lat, bcnt);
      check("dcrz0_latency", lat, 2);
      check_reg("dcrz0_r0", 2'd0, 8'h00);
      check_flags("dcrz0_flags", 1'b1, 1'b0, 1'b0);

      // Requests held during DCRZ must be ignored
      run_op(2'b00, 2'd2, 8'h03, 1'b0, 2'd0, lat, bcnt);
      run_op(2'b11, 2'd2, 8'h00, 1'b1, 2'd1, lat, bcnt);
      check("ignore_latency", lat, 4);
      check_reg("ignore_r2", 2'd2, 8'h00);
      check_reg("ignore_r1", 2'd1, 8'h01);
      check_flags("ignore_flags", 1'b1, 1'b0, 1'b0);

      // Reset while looping aborts without a completion pulse
      run_op(2'b00, 2'd3, 8'h03, 1'b0, 2'd0, lat, bcnt);
      op_valid = 1'b1;
      op       = 2'b11;
      reg_sel  = 2'd3;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(posedge clk); #1;
      check("loop_busy", {31'd0, busy}, 32'd1);
      check_reg("loop_r3", 2'd3, 8'h02);
      reset = 1'b1;
      pulses = 0;
      @(posedge clk); #1;
      if (complete) pulses++;
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check_flags("abort_flags", 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 4; r++) check_reg("abort_reg", r[1:0], 8'h00);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (complete) pulses++;
      end
      check("abort_no_pulse", pulses, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
